// File: rtl/lsb_queue.sv
// Load/store queue: program-ordered memory ops with CDB operand capture,
// head-only dispatch to memory and oldest-first store-ready reporting to the ROB.
module lsb_queue #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ROB_W   = 4,
    parameter int unsigned N_CDB   = 2,
    parameter logic [31:0] IO_BASE = 32'h0003_0000,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    output logic                   flush_done,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic                   issue_we,
    input  logic [1:0]             issue_width,
    input  logic                   issue_sext,
    input  logic [31:0]            issue_vq1,
    input  logic [31:0]            issue_vq2,
    input  logic                   issue_rdy1,
    input  logic                   issue_rdy2,
    input  logic [31:0]            issue_imm,
    input  logic [ROB_W-1:0]       issue_rob_id,
    input  logic [N_CDB-1:0]       cdb_valid,
    input  logic [N_CDB*ROB_W-1:0] cdb_rob_id,
    input  logic [N_CDB*32-1:0]    cdb_val,
    input  logic                   cmt_valid,
    input  logic [ROB_W-1:0]       cmt_rob_id,
    input  logic [ROB_W-1:0]       rob_head,
    output logic                   st_rdy_valid,
    output logic [ROB_W-1:0]       st_rdy_rob_id,
    output logic                   mem_req_valid,
    output logic                   mem_req_we,
    output logic [1:0]             mem_req_width,
    output logic                   mem_req_sext,
    output logic [31:0]            mem_req_addr,
    output logic [31:0]            mem_req_data,
    output logic [ROB_W-1:0]       mem_req_rob_id,
    input  logic                   mem_done,
    output logic [AW:0]            count
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;
    typedef struct packed {
        logic        hit;
        logic [31:0] val;
    } cdb_res_t;

    state_e           state_q, state_d;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [AW:0]      count_q, count_d;
    logic [DEPTH-1:0] busy_q, busy_d, we_q, we_d, sext_q, sext_d;
    logic [DEPTH-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d, cmt_q, cmt_d, rep_q, rep_d;
    logic [1:0]       width_q [DEPTH];
    logic [1:0]       width_d [DEPTH];
    logic [31:0]      vq1_q [DEPTH];
    logic [31:0]      vq1_d [DEPTH];
    logic [31:0]      vq2_q [DEPTH];
    logic [31:0]      vq2_d [DEPTH];
    logic [31:0]      imm_q [DEPTH];
    logic [31:0]      imm_d [DEPTH];
    logic [ROB_W-1:0] rob_q [DEPTH];
    logic [ROB_W-1:0] rob_d [DEPTH];

    logic             push, pop, start_req, rep_fire, rep_found, run, st_rdy_q;
    logic             head_elig, head_survives;
    logic [AW-1:0]    rep_idx, idx;
    logic [AW:0]      len;
    logic [31:0]      head_addr;
    cdb_res_t         hit1, hit2;

    // Lowest-indexed matching bus wins, so scan from the top down.
    function automatic cdb_res_t cdb_lookup(input logic [ROB_W-1:0] tag,
                                            input logic [N_CDB-1:0] v,
                                            input logic [N_CDB*ROB_W-1:0] ids,
                                            input logic [N_CDB*32-1:0] vals);
        cdb_res_t r;
        r = '0;
        for (int k = int'(N_CDB) - 1; k >= 0; k--) begin
            if (v[k] && ids[k*ROB_W +: ROB_W] == tag) begin
                r.hit = 1'b1;
                r.val = vals[k*32 +: 32];
            end
        end
        return r;
    endfunction

    assign flush_done  = ~|(busy_q & ~(we_q & cmt_q));
    assign issue_ready = ~count_q[AW];
    assign count       = count_q;
    assign st_rdy_valid = st_rdy_q;

    assign head_addr     = vq1_q[head_q] + imm_q[head_q];
    assign head_survives = we_q[head_q] & cmt_q[head_q];
    assign head_elig     = busy_q[head_q] && (we_q[head_q] ? cmt_q[head_q] :
                           (rdy1_q[head_q] && (head_addr < IO_BASE || rob_head == rob_q[head_q])));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (head_elig && (!flush || head_survives)) state_d = StReq;
            StReq:   if (mem_done || (flush && !mem_req_we)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req_valid = (state_q == StReq);
        pop           = (state_q == StReq) && mem_done;
        start_req     = (state_q == StIdle) && (state_d == StReq);
    end

    always_comb begin
        busy_d = busy_q; we_d = we_q; sext_d = sext_q; rdy1_d = rdy1_q; rdy2_d = rdy2_q;
        cmt_d = cmt_q; rep_d = rep_q; width_d = width_q; vq1_d = vq1_q; vq2_d = vq2_q;
        imm_d = imm_q; rob_d = rob_q;
        head_d = head_q; tail_d = tail_q; count_d = count_q;
        hit1 = '0; hit2 = '0; idx = '0; len = '0; run = 1'b1;
        rep_fire = 1'b0; rep_found = 1'b0; rep_idx = '0;
        push = issue_valid && issue_ready && !flush;

        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && !rdy1_q[i]) begin
                hit1 = cdb_lookup(vq1_q[i][ROB_W-1:0], cdb_valid, cdb_rob_id, cdb_val);
                if (hit1.hit) begin rdy1_d[i] = 1'b1; vq1_d[i] = hit1.val; end
            end
            if (busy_q[i] && !rdy2_q[i]) begin
                hit2 = cdb_lookup(vq2_q[i][ROB_W-1:0], cdb_valid, cdb_rob_id, cdb_val);
                if (hit2.hit) begin rdy2_d[i] = 1'b1; vq2_d[i] = hit2.val; end
            end
            if (cmt_valid && busy_q[i] && we_q[i] && rob_q[i] == cmt_rob_id) cmt_d[i] = 1'b1;
        end

        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (!rep_found && busy_q[idx] && we_q[idx] && !cmt_q[idx] && !rep_q[idx] &&
                rdy1_q[idx] && rdy2_q[idx]) begin
                rep_found = 1'b1;
                rep_idx   = idx;
            end
        end

        if (pop) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + AW'(1);
        end

        if (flush) begin
            // Survivors: the run of committed stores starting at the (post-pop) head.
            for (int i = 0; i < DEPTH; i++) begin
                idx = head_d + AW'(i);
                if (run && busy_d[idx] && we_q[idx] && cmt_d[idx]) begin
                    len = len + (AW+1)'(1);
                end else begin
                    run         = 1'b0;
                    busy_d[idx] = 1'b0;
                end
            end
            tail_d  = head_d + len[AW-1:0];
            count_d = len;
        end else begin
            if (rep_found) begin
                rep_d[rep_idx] = 1'b1;
                rep_fire       = 1'b1;
            end
            if (push) begin
                hit1 = cdb_lookup(issue_vq1[ROB_W-1:0], cdb_valid, cdb_rob_id, cdb_val);
                hit2 = cdb_lookup(issue_vq2[ROB_W-1:0], cdb_valid, cdb_rob_id, cdb_val);
                busy_d[tail_q]  = 1'b1;
                we_d[tail_q]    = issue_we;
                sext_d[tail_q]  = issue_sext;
                width_d[tail_q] = issue_width;
                imm_d[tail_q]   = issue_imm;
                rob_d[tail_q]   = issue_rob_id;
                cmt_d[tail_q]   = 1'b0;
                rep_d[tail_q]   = 1'b0;
                rdy1_d[tail_q]  = issue_rdy1 || hit1.hit;
                rdy2_d[tail_q]  = issue_rdy2 || hit2.hit;
                vq1_d[tail_q]   = (!issue_rdy1 && hit1.hit) ? hit1.val : issue_vq1;
                vq2_d[tail_q]   = (!issue_rdy2 && hit2.hit) ? hit2.val : issue_vq2;
                tail_d          = tail_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0; tail_q <= '0; count_q <= '0;
            busy_q <= '0; we_q <= '0; sext_q <= '0; rdy1_q <= '0; rdy2_q <= '0;
            cmt_q <= '0; rep_q <= '0;
            width_q <= '{default: '0}; vq1_q <= '{default: '0}; vq2_q <= '{default: '0};
            imm_q <= '{default: '0}; rob_q <= '{default: '0};
            st_rdy_q <= 1'b0; st_rdy_rob_id <= '0;
            mem_req_we <= 1'b0; mem_req_width <= '0; mem_req_sext <= 1'b0;
            mem_req_addr <= '0; mem_req_data <= '0; mem_req_rob_id <= '0;
        end else if (rdy) begin
            head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
            busy_q <= busy_d; we_q <= we_d; sext_q <= sext_d; rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d; cmt_q <= cmt_d; rep_q <= rep_d;
            width_q <= width_d; vq1_q <= vq1_d; vq2_q <= vq2_d; imm_q <= imm_d; rob_q <= rob_d;
            st_rdy_q <= rep_fire;
            if (rep_fire) st_rdy_rob_id <= rob_q[rep_idx];
            if (start_req) begin
                mem_req_we     <= we_q[head_q];
                mem_req_width  <= width_q[head_q];
                mem_req_sext   <= sext_q[head_q];
                mem_req_addr   <= head_addr;
                mem_req_data   <= we_q[head_q] ? vq2_q[head_q] : 32'h0;
                mem_req_rob_id <= rob_q[head_q];
            end
        end else begin
            st_rdy_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: per-cycle vector table with expected outputs,
// plus hand-written sequences for fill/wrap and asynchronous reset mid-request.
module tb_lsb_queue;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, flush_done, issue_valid, issue_ready, issue_we, issue_sext;
    logic [1:0]  issue_width;
    logic [31:0] issue_vq1, issue_vq2, issue_imm;
    logic        issue_rdy1, issue_rdy2;
    logic [3:0]  issue_rob_id, cmt_rob_id, rob_head, st_rdy_rob_id, mem_req_rob_id;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob_id;
    logic [63:0] cdb_val;
    logic        cmt_valid, st_rdy_valid, mem_req_valid, mem_req_we, mem_req_sext, mem_done;
    logic [1:0]  mem_req_width;
    logic [31:0] mem_req_addr, mem_req_data;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsb_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .flush_done(flush_done),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_we(issue_we),
        .issue_width(issue_width), .issue_sext(issue_sext), .issue_vq1(issue_vq1),
        .issue_vq2(issue_vq2), .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2),
        .issue_imm(issue_imm), .issue_rob_id(issue_rob_id), .cdb_valid(cdb_valid),
        .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .cmt_valid(cmt_valid),
        .cmt_rob_id(cmt_rob_id), .rob_head(rob_head), .st_rdy_valid(st_rdy_valid),
        .st_rdy_rob_id(st_rdy_rob_id), .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we),
        .mem_req_width(mem_req_width), .mem_req_sext(mem_req_sext),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_rob_id(mem_req_rob_id), .mem_done(mem_done), .count(count)
    );

    typedef struct {
        logic        en, iv, iwe, isx, r1, r2, cmv, done, fl;
        logic [1:0]  iw, cv;
        logic [31:0] vq1, vq2, imm, c0val, c1val;
        logic [3:0]  rid, cmid, rhead, c0id, c1id;
        logic [4:0]  e_count;
        logic        e_req, e_we, e_sx, e_st, e_fd;
        logic [1:0]  e_w;
        logic [31:0] e_addr, e_data;
        logic [3:0]  e_rid, e_stid;
    } vec_t;

    vec_t v[$];
    vec_t t;

    function automatic vec_t nop(input int cnt, input logic fd);
        vec_t r;
        r = '{default: '0};
        r.en = 1'b1; r.e_count = 5'(cnt); r.e_fd = fd;
        return r;
    endfunction

    function automatic vec_t lda(input vec_t r0, input logic [3:0] rid, input logic [31:0] vq1,
                                 input logic r1, input logic [31:0] imm);
        vec_t r = r0;
        r.iv = 1'b1; r.iwe = 1'b0; r.iw = 2'b00; r.isx = 1'b1; r.rid = rid;
        r.vq1 = vq1; r.r1 = r1; r.vq2 = 32'h0; r.r2 = 1'b1; r.imm = imm;
        return r;
    endfunction

    function automatic vec_t sto(input vec_t r0, input logic [3:0] rid, input logic [31:0] vq1,
                                 input logic [31:0] vq2, input logic [31:0] imm);
        vec_t r = r0;
        r.iv = 1'b1; r.iwe = 1'b1; r.iw = 2'b11; r.isx = 1'b0; r.rid = rid;
        r.vq1 = vq1; r.r1 = 1'b1; r.vq2 = vq2; r.r2 = 1'b1; r.imm = imm;
        return r;
    endfunction

    function automatic vec_t req(input vec_t r0, input logic [31:0] addr, input logic we,
                                 input logic [31:0] data, input logic [3:0] rid);
        vec_t r = r0;
        r.e_req = 1'b1; r.e_addr = addr; r.e_we = we; r.e_data = data; r.e_rid = rid;
        r.e_w = we ? 2'b11 : 2'b00; r.e_sx = ~we;
        return r;
    endfunction

    function automatic vec_t rep(input vec_t r0, input logic [3:0] id);
        vec_t r = r0;
        r.e_st = 1'b1; r.e_stid = id;
        return r;
    endfunction

    function automatic vec_t cmt(input vec_t r0, input logic [3:0] id);
        vec_t r = r0;
        r.cmv = 1'b1; r.cmid = id;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        rdy = r.en; flush = r.fl; mem_done = r.done; rob_head = r.rhead;
        issue_valid = r.iv; issue_we = r.iwe; issue_width = r.iw; issue_sext = r.isx;
        issue_vq1 = r.vq1; issue_vq2 = r.vq2; issue_rdy1 = r.r1; issue_rdy2 = r.r2;
        issue_imm = r.imm; issue_rob_id = r.rid;
        cdb_valid = r.cv; cdb_rob_id = {r.c1id, r.c0id}; cdb_val = {r.c1val, r.c0val};
        cmt_valid = r.cmv; cmt_rob_id = r.cmid;
    endtask

    task automatic step(input vec_t r);
        @(negedge clk);
        drive(r);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input int i, input vec_t r);
        chk($sformatf("v%0d count", i), 32'(count), 32'(r.e_count));
        chk($sformatf("v%0d issue_ready", i), 32'(issue_ready), 32'(r.e_count != 5'd16));
        chk($sformatf("v%0d flush_done", i), 32'(flush_done), 32'(r.e_fd));
        chk($sformatf("v%0d mem_req_valid", i), 32'(mem_req_valid), 32'(r.e_req));
        chk($sformatf("v%0d st_rdy_valid", i), 32'(st_rdy_valid), 32'(r.e_st));
        if (r.e_st) chk($sformatf("v%0d st_rdy_rob_id", i), 32'(st_rdy_rob_id), 32'(r.e_stid));
        if (r.e_req) begin
            chk($sformatf("v%0d addr", i), mem_req_addr, r.e_addr);
            chk($sformatf("v%0d we", i), 32'(mem_req_we), 32'(r.e_we));
            chk($sformatf("v%0d data", i), mem_req_data, r.e_data);
            chk($sformatf("v%0d rob_id", i), 32'(mem_req_rob_id), 32'(r.e_rid));
            chk($sformatf("v%0d width", i), 32'(mem_req_width), 32'(r.e_w));
            chk($sformatf("v%0d sext", i), 32'(mem_req_sext), 32'(r.e_sx));
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(nop(0, 1'b1));
        repeat (2) @(posedge clk);
        #1;
        chk("reset count", 32'(count), 32'd0);
        chk("reset req", 32'(mem_req_valid), 32'd0);
        chk("reset st_rdy", 32'(st_rdy_valid), 32'd0);
        chk("reset addr", mem_req_addr, 32'd0);
        chk("reset issue_ready", 32'(issue_ready), 32'd1);
        chk("reset flush_done", 32'(flush_done), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // Plain load with negative offset
        v.push_back(lda(nop(1, 0), 4'd1, 32'h100, 1'b1, 32'hFFFF_FFFC));
        v.push_back(req(nop(1, 0), 32'hFC, 1'b0, 32'h0, 4'd1));
        t = nop(0, 1); t.done = 1'b1; v.push_back(t);
        // Store waits on tag 3, captured from bus 1, reported once, then committed
        t = sto(nop(1, 0), 4'd2, 32'd3, 32'hDEAD_BEEF, 32'h10); t.r1 = 1'b0; v.push_back(t);
        t = nop(1, 0); t.cv = 2'b11; t.c0id = 4'd5; t.c0val = 32'h1111;
        t.c1id = 4'd3; t.c1val = 32'h2000; v.push_back(t);
        v.push_back(rep(nop(1, 0), 4'd2));
        v.push_back(nop(1, 0));
        v.push_back(cmt(nop(1, 1), 4'd2));
        v.push_back(req(nop(1, 1), 32'h2010, 1'b1, 32'hDEAD_BEEF, 4'd2));
        t = nop(0, 1); t.done = 1'b1; v.push_back(t);
        // Issue-cycle bypass, both buses match: bus 0 wins
        t = lda(nop(1, 0), 4'd4, 32'd7, 1'b0, 32'd8); t.cv = 2'b11;
        t.c0id = 4'd7; t.c0val = 32'h400; t.c1id = 4'd7; t.c1val = 32'h800; v.push_back(t);
        v.push_back(req(nop(1, 0), 32'h408, 1'b0, 32'h0, 4'd4));
        t = nop(0, 1); t.done = 1'b1; v.push_back(t);
        // I/O load waits for rob_head
        v.push_back(lda(nop(1, 0), 4'd6, 32'h3_0000, 1'b1, 32'd0));
        v.push_back(nop(1, 0));
        t = req(nop(1, 0), 32'h3_0000, 1'b0, 32'h0, 4'd6); t.rhead = 4'd6; v.push_back(t);
        t = nop(0, 1); t.done = 1'b1; t.rhead = 4'd6; v.push_back(t);
        // Just below IO_BASE is ordinary memory
        v.push_back(lda(nop(1, 0), 4'd7, 32'h2_FFFC, 1'b1, 32'd3));
        v.push_back(req(nop(1, 0), 32'h2_FFFF, 1'b0, 32'h0, 4'd7));
        t = nop(0, 1); t.done = 1'b1; v.push_back(t);
        // S,S,L,S; commit first two, flush keeps 2
        v.push_back(sto(nop(1, 0), 4'd1, 32'h100, 32'hA1, 32'd0));
        v.push_back(rep(sto(nop(2, 0), 4'd2, 32'h104, 32'hA2, 32'd0), 4'd1));
        v.push_back(rep(lda(nop(3, 0), 4'd3, 32'd9, 1'b0, 32'd0), 4'd2));
        v.push_back(sto(nop(4, 0), 4'd4, 32'h108, 32'hA4, 32'd0));
        v.push_back(rep(cmt(nop(4, 0), 4'd1), 4'd4));
        v.push_back(req(cmt(nop(4, 0), 4'd2), 32'h100, 1'b1, 32'hA1, 4'd1));
        t = req(nop(2, 1), 32'h100, 1'b1, 32'hA1, 4'd1); t.fl = 1'b1; v.push_back(t);
        t = nop(1, 1); t.done = 1'b1; v.push_back(t);
        v.push_back(req(nop(1, 1), 32'h104, 1'b1, 32'hA2, 4'd2));
        t = nop(0, 1); t.done = 1'b1; v.push_back(t);
        // Flush with same-cycle commit of third store; issue in that cycle is dropped
        v.push_back(sto(nop(1, 0), 4'd5, 32'h200, 32'hB5, 32'd0));
        v.push_back(rep(sto(nop(2, 0), 4'd6, 32'h204, 32'hB6, 32'd0), 4'd5));
        v.push_back(cmt(rep(sto(nop(3, 0), 4'd7, 32'h208, 32'hB7, 32'd0), 4'd6), 4'd5));
        v.push_back(req(rep(cmt(nop(3, 0), 4'd6), 4'd7), 32'h200, 1'b1, 32'hB5, 4'd5));
        v.push_back(req(lda(nop(4, 0), 4'd8, 32'd9, 1'b0, 32'd0), 32'h200, 1'b1, 32'hB5, 4'd5));
        t = req(cmt(lda(nop(3, 1), 4'd9, 32'h60, 1'b1, 32'd0), 4'd7), 32'h200, 1'b1, 32'hB5, 4'd5);
        t.fl = 1'b1; v.push_back(t);
        t = nop(2, 1); t.done = 1'b1; v.push_back(t);
        v.push_back(req(nop(2, 1), 32'h204, 1'b1, 32'hB6, 4'd6));
        t = nop(1, 1); t.done = 1'b1; v.push_back(t);
        v.push_back(req(nop(1, 1), 32'h208, 1'b1, 32'hB7, 4'd7));
        t = nop(0, 1); t.done = 1'b1; v.push_back(t);
        // In-flight load dropped by flush
        v.push_back(lda(nop(1, 0), 4'd9, 32'h40, 1'b1, 32'd0));
        v.push_back(req(nop(1, 0), 32'h40, 1'b0, 32'h0, 4'd9));
        t = nop(0, 1); t.fl = 1'b1; v.push_back(t);
        v.push_back(nop(0, 1));
        // rdy=0 freezes issue and completion
        t = lda(nop(0, 1), 4'd10, 32'h50, 1'b1, 32'd0); t.en = 1'b0; v.push_back(t);
        v.push_back(lda(nop(1, 0), 4'd10, 32'h50, 1'b1, 32'd0));
        v.push_back(req(nop(1, 0), 32'h50, 1'b0, 32'h0, 4'd10));
        t = req(nop(1, 0), 32'h50, 1'b0, 32'h0, 4'd10); t.en = 1'b0; t.done = 1'b1; v.push_back(t);
        t = nop(0, 1); t.done = 1'b1; v.push_back(t);

        for (int i = 0; i < v.size(); i++) begin
            step(v[i]);
            check_vec(i, v[i]);
        end

        // Fill to DEPTH, reject while full, pop one, refill the wrapped slot
        step(lda(nop(0, 0), 4'd0, 32'h10, 1'b1, 32'd0));
        for (int k = 1; k < 16; k++) step(lda(nop(0, 0), 4'(k), 32'd15, 1'b0, 32'd0));
        chk("fill count", 32'(count), 32'd16);
        chk("fill issue_ready", 32'(issue_ready), 32'd0);
        chk("fill req", 32'(mem_req_valid), 32'd1);
        chk("fill addr", mem_req_addr, 32'h10);
        step(lda(nop(0, 0), 4'd1, 32'h70, 1'b1, 32'd0));
        chk("full ignore count", 32'(count), 32'd16);
        t = nop(0, 0); t.done = 1'b1; step(t);
        chk("pop count", 32'(count), 32'd15);
        chk("pop issue_ready", 32'(issue_ready), 32'd1);
        chk("pop req", 32'(mem_req_valid), 32'd0);
        step(lda(nop(0, 0), 4'd2, 32'd15, 1'b0, 32'd0));
        chk("refill count", 32'(count), 32'd16);
        chk("refill issue_ready", 32'(issue_ready), 32'd0);
        t = nop(0, 0); t.fl = 1'b1; step(t);
        chk("full flush count", 32'(count), 32'd0);
        chk("full flush done", 32'(flush_done), 32'd1);
        chk("full flush ready", 32'(issue_ready), 32'd1);

        // Asynchronous reset while a request is outstanding
        step(lda(nop(0, 0), 4'd3, 32'h20, 1'b1, 32'd0));
        step(nop(0, 0));
        chk("pre-reset req", 32'(mem_req_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async reset req", 32'(mem_req_valid), 32'd0);
        chk("async reset count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
